// File: rtl/nasti_pkg.sv
// Shared NASTI definitions: maximum field widths, per-channel payload structs,
// payload widths for sizing channel buffers, and response encodings.
package nasti_pkg;

   localparam int NASTI_ID_W   = 16;
   localparam int NASTI_ADDR_W = 64;
   localparam int NASTI_DATA_W = 256;
   localparam int NASTI_USER_W = 8;
   localparam int NASTI_STRB_W = NASTI_DATA_W / 8;

   localparam logic [1:0] RESP_OKAY   = 2'd0;
   localparam logic [1:0] RESP_EXOKAY = 2'd1;
   localparam logic [1:0] RESP_SLVERR = 2'd2;
   localparam logic [1:0] RESP_DECERR = 2'd3;

   typedef struct packed {
      logic [NASTI_ID_W-1:0]   id;
      logic [NASTI_ADDR_W-1:0] addr;
      logic [7:0]              len;
      logic [2:0]              size;
      logic [1:0]              burst;
      logic                    lock;
      logic [3:0]              cache;
      logic [2:0]              prot;
      logic [3:0]              qos;
      logic [3:0]              region;
      logic [NASTI_USER_W-1:0] user;
   } nasti_aw_payload_t;

   typedef nasti_aw_payload_t nasti_ar_payload_t;

   typedef struct packed {
      logic [NASTI_DATA_W-1:0] data;
      logic [NASTI_STRB_W-1:0] strb;
      logic [NASTI_USER_W-1:0] user;
   } nasti_w_payload_t;

   typedef struct packed {
      logic [NASTI_ID_W-1:0]   id;
      logic [1:0]              resp;
      logic [NASTI_USER_W-1:0] user;
   } nasti_b_payload_t;

   typedef struct packed {
      logic [NASTI_ID_W-1:0]   id;
      logic [NASTI_DATA_W-1:0] data;
      logic [1:0]              resp;
      logic [NASTI_USER_W-1:0] user;
   } nasti_r_payload_t;

   localparam int NASTI_AW_PAYLOAD_W = $bits(nasti_aw_payload_t);
   localparam int NASTI_AR_PAYLOAD_W = $bits(nasti_ar_payload_t);
   localparam int NASTI_W_PAYLOAD_W  = $bits(nasti_w_payload_t);
   localparam int NASTI_B_PAYLOAD_W  = $bits(nasti_b_payload_t);
   localparam int NASTI_R_PAYLOAD_W  = $bits(nasti_r_payload_t);

endpackage

// File: rtl/nasti_buf_mem.sv
// Entry storage for the channel buffer: one write port, one asynchronous read
// port, kept separate so it can be replaced by an SRAM macro.
module nasti_buf_mem
   import nasti_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int WIDTH  = 65,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [WIDTH-1:0]  rdata
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/nasti_chan_buf.sv
// Channel-agnostic NASTI buffer with optional store-and-forward release of
// whole bursts; pointer, occupancy and burst bookkeeping live here.
module nasti_chan_buf
   import nasti_pkg::*;
#(
   parameter int PAYLOAD_W = 64,
   parameter int DEPTH     = 4,
   parameter bit STORE_FWD = 1'b0,
   parameter int CNT_W     = $clog2(DEPTH + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [PAYLOAD_W-1:0] s_payload,
   input  logic                 s_last,
   input  logic                 s_valid,
   output logic                 s_ready,
   output logic [PAYLOAD_W-1:0] m_payload,
   output logic                 m_last,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic [CNT_W-1:0]     count,
   output logic [CNT_W-1:0]     bursts,
   output logic                 ovf_err
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d, bursts_q, bursts_d;
   logic             s_ready_q, s_ready_d;
   logic             ovf_q, ovf_d;
   logic             push, pop, burst_in, burst_out;

   assign push      = s_valid & s_ready_q;
   assign pop       = m_valid & m_ready;
   assign burst_in  = push & s_last;
   assign burst_out = pop & m_last;

   // In store-and-forward mode a beat is only offered once its burst is complete.
   assign m_valid = STORE_FWD ? ((count_q != '0) && (bursts_q != '0))
                              : (count_q != '0);

   always_comb begin
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);

      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      case ({burst_in, burst_out})
         2'b10:   bursts_d = bursts_q + CNT_W'(1);
         2'b01:   bursts_d = bursts_q - CNT_W'(1);
         default: bursts_d = bursts_q;
      endcase

      // Ready is registered from next occupancy so it never depends on m_ready.
      s_ready_d = (count_d != FULL_CNT);
      ovf_d     = ovf_q | (STORE_FWD && (count_q == FULL_CNT) && (bursts_q == '0));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         bursts_q  <= '0;
         s_ready_q <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         bursts_q  <= bursts_d;
         s_ready_q <= s_ready_d;
         ovf_q     <= ovf_d;
      end
   end

   nasti_buf_mem #(
      .DEPTH  (DEPTH),
      .WIDTH  (PAYLOAD_W + 1),
      .ADDR_W (PTR_W)
   ) u_mem (
      .clk   (clk),
      .we    (push),
      .waddr (wr_ptr_q),
      .wdata ({s_last, s_payload}),
      .raddr (rd_ptr_q),
      .rdata ({m_last, m_payload})
   );

   assign s_ready = s_ready_q;
   assign count   = count_q;
   assign bursts  = bursts_q;
   assign ovf_err = ovf_q;

endmodule

// File: tb/tb_nasti_chan_buf.sv
// Scoreboard bench for nasti_chan_buf: a cut-through instance and a
// store-and-forward instance sharing clock and reset.
module tb_nasti_chan_buf;

   localparam int PW = 16;

   logic          clk, rst;

   logic [PW-1:0] s_payload0, m_payload0;
   logic          s_last0, s_valid0, s_ready0, m_last0, m_valid0, m_ready0, ovf_err0;
   logic [2:0]    count0, bursts0;

   logic [PW-1:0] s_payload1, m_payload1;
   logic          s_last1, s_valid1, s_ready1, m_last1, m_valid1, m_ready1, ovf_err1;
   logic [2:0]    count1, bursts1;

   logic [PW:0]   exp0_q[$];
   logic [PW:0]   exp1_q[$];
   int            checks   = 0;
   int            failures = 0;

   nasti_chan_buf #(.PAYLOAD_W(PW), .DEPTH(4), .STORE_FWD(1'b0)) dut0 (
      .clk(clk), .rst(rst),
      .s_payload(s_payload0), .s_last(s_last0), .s_valid(s_valid0), .s_ready(s_ready0),
      .m_payload(m_payload0), .m_last(m_last0), .m_valid(m_valid0), .m_ready(m_ready0),
      .count(count0), .bursts(bursts0), .ovf_err(ovf_err0)
   );

   nasti_chan_buf #(.PAYLOAD_W(PW), .DEPTH(4), .STORE_FWD(1'b1)) dut1 (
      .clk(clk), .rst(rst),
      .s_payload(s_payload1), .s_last(s_last1), .s_valid(s_valid1), .s_ready(s_ready1),
      .m_payload(m_payload1), .m_last(m_last1), .m_valid(m_valid1), .m_ready(m_ready1),
      .count(count1), .bursts(bursts1), .ovf_err(ovf_err1)
   );

   always #5 clk = ~clk;

   task automatic test_reset();
      rst = 1'b1;
      @(negedge clk);
      checks++; if (s_ready0 !== 1'b0) begin failures++; $display("FAIL rst_s_ready got=%b exp=0", s_ready0); end
      checks++; if (m_valid0 !== 1'b0) begin failures++; $display("FAIL rst_m_valid got=%b exp=0", m_valid0); end
      checks++; if (count0 !== 3'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", count0); end
      rst = 1'b0;
      @(negedge clk);
      checks++; if (s_ready0 !== 1'b1) begin failures++; $display("FAIL idle_s_ready got=%b exp=1", s_ready0); end
      checks++; if (m_valid0 !== 1'b0) begin failures++; $display("FAIL idle_m_valid got=%b exp=0", m_valid0); end
      checks++; if (count0 !== 3'd0) begin failures++; $display("FAIL idle_count got=%0d exp=0", count0); end
      checks++; if (bursts0 !== 3'd0) begin failures++; $display("FAIL idle_bursts got=%0d exp=0", bursts0); end
      checks++; if (s_ready1 !== 1'b1) begin failures++; $display("FAIL idle_s_ready_sf got=%b exp=1", s_ready1); end
      checks++; if (ovf_err1 !== 1'b0) begin failures++; $display("FAIL idle_ovf got=%b exp=0", ovf_err1); end
   endtask

   task automatic test_fill_drain();
      int sent = 0, popped = 0, cyc = 0, gaps = 0;
      logic [PW:0] exp;
      while (sent < 4 && cyc < 20) begin
         @(negedge clk); cyc++;
         m_ready0 = 1'b0; s_valid0 = 1'b1; s_last0 = 1'b1; s_payload0 = PW'(16'hA0 + sent);
         if (s_ready0) begin exp0_q.push_back({s_last0, s_payload0}); sent++; end
      end
      checks++; if (sent != 4) begin failures++; $display("FAIL fill_timeout got=%0d exp=4", sent); end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         s_payload0 = PW'(16'hA0 + sent);
         checks++; if (s_ready0 !== 1'b0) begin failures++; $display("FAIL full_s_ready got=%b exp=0", s_ready0); end
         checks++; if (count0 !== 3'd4) begin failures++; $display("FAIL full_count got=%0d exp=4", count0); end
      end
      cyc = 0;
      while (popped < 5 && cyc < 20) begin
         @(negedge clk); cyc++;
         m_ready0 = 1'b1; s_valid0 = (sent < 5); s_payload0 = PW'(16'hA0 + sent);
         if (s_valid0 && s_ready0) begin exp0_q.push_back({s_last0, s_payload0}); sent++; end
         if (m_valid0) begin
            checks++;
            if (exp0_q.size() == 0) begin failures++; $display("FAIL drain_extra got=%h exp=none", m_payload0); end
            else begin
               exp = exp0_q.pop_front();
               if ({m_last0, m_payload0} !== exp) begin failures++; $display("FAIL drain_data got=%h exp=%h", {m_last0, m_payload0}, exp); end
            end
            popped++;
         end else gaps++;
      end
      @(negedge clk);
      s_valid0 = 1'b0; m_ready0 = 1'b0;
      checks++; if (popped != 5) begin failures++; $display("FAIL drain_timeout got=%0d exp=5", popped); end
      checks++; if (gaps != 0) begin failures++; $display("FAIL drain_gaps got=%0d exp=0", gaps); end
      checks++; if (count0 !== 3'd0) begin failures++; $display("FAIL drain_count got=%0d exp=0", count0); end
      checks++; if (m_valid0 !== 1'b0) begin failures++; $display("FAIL drain_m_valid got=%b exp=0", m_valid0); end
   endtask

   task automatic test_back_to_back();
      int sent = 0, popped = 0, cyc = 0, stream_err = 0;
      logic [PW:0] exp;
      while (popped < 16 && cyc < 40) begin
         @(negedge clk); cyc++;
         m_ready0 = 1'b1; s_valid0 = (sent < 16); s_last0 = 1'b1; s_payload0 = PW'(sent);
         if (cyc >= 2 && cyc <= 17 && (count0 !== 3'd1 || m_valid0 !== 1'b1 || s_ready0 !== 1'b1)) stream_err++;
         if (s_valid0 && s_ready0) begin exp0_q.push_back({s_last0, s_payload0}); sent++; end
         if (m_valid0) begin
            checks++;
            if (exp0_q.size() == 0) begin failures++; $display("FAIL stream_extra got=%h exp=none", m_payload0); end
            else begin
               exp = exp0_q.pop_front();
               if ({m_last0, m_payload0} !== exp) begin failures++; $display("FAIL stream_data got=%h exp=%h", {m_last0, m_payload0}, exp); end
            end
            popped++;
         end
      end
      @(negedge clk);
      s_valid0 = 1'b0; m_ready0 = 1'b0;
      checks++; if (cyc != 17) begin failures++; $display("FAIL stream_cycles got=%0d exp=17", cyc); end
      checks++; if (stream_err != 0) begin failures++; $display("FAIL stream_occupancy got=%0d exp=0", stream_err); end
      checks++; if (count0 !== 3'd0) begin failures++; $display("FAIL stream_count got=%0d exp=0", count0); end
   endtask

   task automatic test_store_fwd();
      int sent = 0, popped = 0, cyc = 0, early = 0;
      logic [PW:0] exp;
      while (sent < 3 && cyc < 20) begin
         @(negedge clk); cyc++;
         m_ready1 = 1'b1; s_valid1 = 1'b1; s_last1 = (sent == 2); s_payload1 = PW'(16'hB0 + sent);
         if (m_valid1) early++;
         if (s_ready1) begin exp1_q.push_back({s_last1, s_payload1}); sent++; end
      end
      checks++; if (early != 0) begin failures++; $display("FAIL sf_early_valid got=%0d exp=0", early); end
      cyc = 0;
      while (popped < 3 && cyc < 20) begin
         @(negedge clk); cyc++;
         s_valid1 = 1'b0; m_ready1 = 1'b1;
         if (cyc == 1) begin
            checks++; if (m_valid1 !== 1'b1) begin failures++; $display("FAIL sf_valid got=%b exp=1", m_valid1); end
            checks++; if (bursts1 !== 3'd1) begin failures++; $display("FAIL sf_bursts got=%0d exp=1", bursts1); end
            checks++; if (count1 !== 3'd3) begin failures++; $display("FAIL sf_count got=%0d exp=3", count1); end
         end
         if (m_valid1) begin
            checks++;
            if (exp1_q.size() == 0) begin failures++; $display("FAIL sf_extra got=%h exp=none", m_payload1); end
            else begin
               exp = exp1_q.pop_front();
               if ({m_last1, m_payload1} !== exp) begin failures++; $display("FAIL sf_data got=%h exp=%h", {m_last1, m_payload1}, exp); end
            end
            popped++;
         end
      end
      @(negedge clk);
      m_ready1 = 1'b0;
      checks++; if (popped != 3) begin failures++; $display("FAIL sf_timeout got=%0d exp=3", popped); end
      checks++; if (bursts1 !== 3'd0) begin failures++; $display("FAIL sf_bursts_after got=%0d exp=0", bursts1); end
      checks++; if (m_valid1 !== 1'b0) begin failures++; $display("FAIL sf_valid_after got=%b exp=0", m_valid1); end
   endtask

   task automatic test_ovf();
      int sent = 0, cyc = 0;
      while (sent < 4 && cyc < 20) begin
         @(negedge clk); cyc++;
         m_ready1 = 1'b0; s_valid1 = 1'b1; s_last1 = 1'b0; s_payload1 = PW'(16'hC0 + sent);
         if (s_ready1) sent++;
      end
      @(negedge clk);
      checks++; if (count1 !== 3'd4) begin failures++; $display("FAIL ovf_count got=%0d exp=4", count1); end
      checks++; if (bursts1 !== 3'd0) begin failures++; $display("FAIL ovf_bursts got=%0d exp=0", bursts1); end
      checks++; if (s_ready1 !== 1'b0) begin failures++; $display("FAIL ovf_s_ready got=%b exp=0", s_ready1); end
      @(negedge clk);
      checks++; if (ovf_err1 !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", ovf_err1); end
      checks++; if (ovf_err0 !== 1'b0) begin failures++; $display("FAIL ovf_cut_through got=%b exp=0", ovf_err0); end
      repeat (3) @(negedge clk);
      checks++; if (ovf_err1 !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", ovf_err1); end
      checks++; if (m_valid1 !== 1'b0) begin failures++; $display("FAIL ovf_m_valid got=%b exp=0", m_valid1); end
   endtask

   task automatic test_reset_mid_burst();
      int sent = 0, popped = 0, cyc = 0;
      logic [PW:0] exp;
      while (sent < 2 && cyc < 20) begin
         @(negedge clk); cyc++;
         m_ready0 = 1'b0; s_valid0 = 1'b1; s_last0 = (sent == 1); s_payload0 = PW'(16'h11 * (sent + 1));
         if (s_ready0) sent++;
      end
      @(negedge clk);
      s_valid0 = 1'b0; s_valid1 = 1'b0;
      checks++; if (count0 !== 3'd2) begin failures++; $display("FAIL mid_count_pre got=%0d exp=2", count0); end
      rst = 1'b1;
      #1;
      checks++; if (count0 !== 3'd0) begin failures++; $display("FAIL mid_count got=%0d exp=0", count0); end
      checks++; if (m_valid0 !== 1'b0) begin failures++; $display("FAIL mid_m_valid got=%b exp=0", m_valid0); end
      checks++; if (count1 !== 3'd0) begin failures++; $display("FAIL mid_count_sf got=%0d exp=0", count1); end
      checks++; if (ovf_err1 !== 1'b0) begin failures++; $display("FAIL mid_ovf_clear got=%b exp=0", ovf_err1); end
      exp0_q.delete();
      exp1_q.delete();
      @(negedge clk);
      rst = 1'b0;
      sent = 0; cyc = 0;
      while (popped < 1 && cyc < 10) begin
         @(negedge clk); cyc++;
         m_ready0 = 1'b1; s_valid0 = (sent < 1); s_last0 = 1'b1; s_payload0 = PW'(16'h55);
         if (s_valid0 && s_ready0) begin exp0_q.push_back({s_last0, s_payload0}); sent++; end
         if (m_valid0) begin
            checks++;
            if (exp0_q.size() == 0) begin failures++; $display("FAIL mid_stale got=%h exp=none", {m_last0, m_payload0}); end
            else begin
               exp = exp0_q.pop_front();
               if ({m_last0, m_payload0} !== exp) begin failures++; $display("FAIL mid_first got=%h exp=%h", {m_last0, m_payload0}, exp); end
            end
            popped++;
         end
      end
      @(negedge clk);
      s_valid0 = 1'b0; m_ready0 = 1'b0;
      checks++; if (popped != 1) begin failures++; $display("FAIL mid_timeout got=%0d exp=1", popped); end
      checks++; if (count0 !== 3'd0) begin failures++; $display("FAIL mid_count_end got=%0d exp=0", count0); end
   endtask

   initial begin
      clk = 1'b0; rst = 1'b1;
      s_payload0 = '0; s_last0 = 1'b0; s_valid0 = 1'b0; m_ready0 = 1'b0;
      s_payload1 = '0; s_last1 = 1'b0; s_valid1 = 1'b0; m_ready1 = 1'b0;
      test_reset();
      test_fill_drain();
      test_back_to_back();
      test_store_fwd();
      test_ovf();
      test_reset_mid_burst();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/nasti_chan_buf.md
Name: nasti_chan_buf

Overview:
- Parametrised, channel-agnostic buffer for one NASTI channel (AW, W, B, AR or R), placed between a master-side and a slave-side channel.
- Carries a flattened payload plus the last flag, with valid/ready on both sides.
- Depth is configurable.
- Optional store-and-forward mode releases data only once a complete burst (terminated by last) is held, so downstream never stalls mid-burst.

Parameters:
- PAYLOAD_W, 64, width of the flattened channel payload (id, addr, data, strb, resp, user, etc., excluding valid/ready/last).
- DEPTH, 4, number of entries; power of two, minimum 2.
- STORE_FWD, 0, 1 holds output until at least one full burst is buffered.
- CNT_W, $clog2(DEPTH+1), width of the occupancy and burst counters (derived; not overridden).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- s_payload  in  PAYLOAD_W  upstream payload
- s_last  in  1  upstream last beat of burst (tie 1 for AW/AR/B)
- s_valid  in  1  upstream valid
- s_ready  out  1  upstream ready
- m_payload  out  PAYLOAD_W  downstream payload
- m_last  out  1  downstream last
- m_valid  out  1  downstream valid
- m_ready  in  1  downstream ready
- count  out  CNT_W  entries currently held
- bursts  out  CNT_W  complete bursts (last beats) currently held
- ovf_err  out  1  sticky: store-and-forward deadlock detected

Behaviour:
- Reset (async assert, sync release): wr/rd pointers=0, count=0, bursts=0, ovf_err=0, m_valid=0, s_ready=0 while rst high.
- Push when s_valid & s_ready; pop when m_valid & m_ready.
- s_ready = (count != DEPTH); registered-state only, no combinational path from m_ready.
- Full: no push even if a pop occurs in the same cycle.
- Simultaneous push and pop, not full and not empty: count unchanged; both pointers advance.
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- No fall-through: a beat pushed in cycle t is presented on m_* no earlier than t+1. Minimum latency is 1 cycle; full throughput is 1 beat/cycle when DEPTH>=2.
- STORE_FWD=0: m_valid = (count != 0).
- STORE_FWD=1: m_valid = (count != 0) & (bursts != 0).
- bursts: +1 on push with s_last, -1 on pop with m_last; unchanged when both happen in one cycle.
- m_payload/m_last are driven from the read pointer entry. They must be stable while m_valid & !m_ready; contents under m_valid=0 are don't-care.
- Once asserted, m_valid does not drop until the pop handshake (AXI rule). Holds in both modes because bursts cannot decrease without a pop.
- ovf_err (STORE_FWD=1 only): set when count==DEPTH & bursts==0, i.e. a burst is longer than DEPTH and will deadlock. Sticky until rst. Always 0 when STORE_FWD=0.
- Reset mid-burst: all held beats are discarded; no partial burst is emitted after release.
- count never exceeds DEPTH. A pop is never performed when count==0.

Decomposition:
- Shared package nasti_pkg holds:
  - max-width constants: ID 16, ADDR 64, DATA 256, USER 8
  - packed struct typedefs for the aw/w/b/ar/r payloads
  - localparams for each payload width, so instances set PAYLOAD_W = $bits(nasti_w_payload_t) etc.
  - resp encodings: OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3
- One natural sub-module: nasti_buf_mem, a DEPTH x (PAYLOAD_W+1) register array with one write port and one asynchronous read port, so it can later be swapped for SRAM.
- Pointer, counter and flag logic stays in nasti_chan_buf.

Test Plan:
- Reset then idle: rst pulse -> s_ready=0 during rst, s_ready=1, m_valid=0, count=0 one cycle after release.
- DEPTH=4, STORE_FWD=0, m_ready=0, push 5 beats 0xA0..0xA4 -> s_ready drops after 4th, count=4, 5th held. Then m_ready=1 -> 0xA0..0xA4 emitted in order, 1 beat/cycle, count returns to 0.
- Continuous stream with s_valid=m_ready=1 for 16 beats, payload=index -> output identical sequence, latency 1, count stays 1, pointers wrap 4 times with no loss.
- STORE_FWD=1, push 3-beat burst (last on 3rd) with m_ready=1 -> m_valid stays 0 until the cycle after the 3rd beat. bursts=1, then 0 after the pop carrying m_last.
- STORE_FWD=1, DEPTH=4, 5-beat burst -> count=4, bursts=0, ovf_err=1 and remains 1 until rst.
- Assert rst after 2 beats pushed with m_ready=0 -> count=0, m_valid=0 immediately. After release no stale beat appears; a new beat 0x55 is the first output.
